// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - fetch/load-store arbiter for the shared ROM/RAM memory port
// Optional feature macro: MEMORY_ARBITER_STATS_EN (grant and conflict counters).
module memory_arbiter #(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        fetchReq,
  input  logic [31:0] fetchAddress,
  output logic        fetchReady,
  output logic        fetchValid,
  output logic [31:0] fetchData,
  input  logic        dataReq,
  input  logic        dataWriteEnable,
  input  logic [31:0] dataAddress,
  input  logic [31:0] dataIn,
  output logic        dataReady,
  output logic        dataValid,
  output logic [31:0] dataOut,
  output logic        dataFault,
  output logic [31:0] memAddress,
  output logic        memReadEnable,
  output logic        memWriteEnable,
  output logic [31:0] memDataIn,
  input  logic [31:0] memDataOut,
`ifdef MEMORY_ARBITER_STATS_EN
  output logic [31:0] fetchGrantCount,
  output logic [31:0] dataGrantCount,
  output logic [31:0] conflictCount,
`endif
  output logic [1:0]  grantState
);

  typedef enum logic [1:0] {
    GRANT_IDLE  = 2'd0,
    GRANT_FETCH = 2'd1,
    GRANT_DATA  = 2'd2
  } grant_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

  grant_t     grant;
  logic [3:0] streakCount;
  logic       storeToRom;

  assign storeToRom = dataWriteEnable && !dataAddress[10];

  // Data wins contention until it has held the port STREAK_MAX times in a row.
  always_comb begin
    grant = GRANT_IDLE;
    if (fetchReq && dataReq)
      grant = (streakCount == STREAK_MAX) ? GRANT_FETCH : GRANT_DATA;
    else if (fetchReq)
      grant = GRANT_FETCH;
    else if (dataReq)
      grant = GRANT_DATA;
  end

  assign fetchReady = (grant == GRANT_FETCH);
  assign dataReady  = (grant == GRANT_DATA);

  always_comb begin
    memAddress     = 32'd0;
    memReadEnable  = 1'b0;
    memWriteEnable = 1'b0;
    memDataIn      = 32'd0;
    case (grant)
      GRANT_FETCH: begin
        memAddress    = fetchAddress;
        memReadEnable = 1'b1;
      end
      GRANT_DATA: begin
        memAddress     = dataAddress;
        memDataIn      = dataIn;
        memReadEnable  = !dataWriteEnable;
        memWriteEnable = dataWriteEnable && dataAddress[10];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      fetchValid  <= 1'b0;
      fetchData   <= 32'd0;
      dataValid   <= 1'b0;
      dataOut     <= 32'd0;
      dataFault   <= 1'b0;
      grantState  <= GRANT_IDLE;
      streakCount <= 4'd0;
    end else begin
      fetchValid <= (grant == GRANT_FETCH);
      dataValid  <= (grant == GRANT_DATA);
      dataFault  <= (grant == GRANT_DATA) && storeToRom;
      grantState <= grant;
      if (grant == GRANT_FETCH)
        fetchData <= memDataOut;
      if (grant == GRANT_DATA)
        dataOut <= dataWriteEnable ? 32'd0 : memDataOut;
      if (!fetchReq || grant == GRANT_FETCH)
        streakCount <= 4'd0;
      else if (grant == GRANT_DATA && streakCount != STREAK_MAX)
        streakCount <= streakCount + 4'd1;
    end
  end

`ifdef MEMORY_ARBITER_STATS_EN
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      fetchGrantCount <= 32'd0;
      dataGrantCount  <= 32'd0;
      conflictCount   <= 32'd0;
    end else begin
      if (grant == GRANT_FETCH)
        fetchGrantCount <= fetchGrantCount + 32'd1;
      if (grant == GRANT_DATA)
        dataGrantCount <= dataGrantCount + 32'd1;
      if (fetchReq && dataReq)
        conflictCount <= conflictCount + 32'd1;
    end
  end
`endif

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Single-port arbiter sharing the unified instruction/data memory (ROM window at address bit 10 = 0, RAM window at bit 10 = 1) between the fetch stage and the load/store stage. One memory transaction per cycle; each requester sees a ready/valid handshake with registered read data. Data port has priority, bounded by a streak counter so fetch cannot starve. Writes that target the ROM window are blocked and flagged.

## Interface
- MAX_DATA_STREAK, 4: consecutive contended data grants before fetch is forced through (1..15).
- clk  in  1  system clock, rising edge.
- resetN  in  1  asynchronous, active-low reset.
- fetchReq  in  1  fetch read request; held with fetchAddress until fetchReady.
- fetchAddress  in  32  fetch byte address.
- fetchReady  out  1  fetch granted this cycle (combinational).
- fetchValid  out  1  fetchData valid (registered pulse).
- fetchData  out  32  fetched word.
- dataReq  in  1  load/store request; held with dataAddress/dataWriteEnable/dataIn until dataReady.
- dataWriteEnable  in  1  1 = store, 0 = load.
- dataAddress  in  32  data byte address.
- dataIn  in  32  store data.
- dataReady  out  1  data granted this cycle (combinational).
- dataValid  out  1  load data valid / store acknowledged (registered pulse).
- dataOut  out  32  load data; 0 for stores.
- dataFault  out  1  registered pulse: store into ROM window was dropped.
- memAddress  out  32  to memory.
- memReadEnable  out  1  to memory.
- memWriteEnable  out  1  to memory.
- memDataIn  out  32  to memory.
- memDataOut  in  32  from memory, combinational read.
- grantState  out  2  registered: 0 IDLE, 1 FETCH, 2 DATA (last cycle's grant).

## Operation
- Grant decision each cycle from current requests and streakCount:
  - only fetchReq → FETCH; only dataReq → DATA; neither → IDLE.
  - both: DATA unless streakCount == MAX_DATA_STREAK, then FETCH.
- streakCount (4 bits): increments on a DATA grant while fetchReq is high; clears on any FETCH grant or any cycle fetchReq is low; saturates at MAX_DATA_STREAK.
- FETCH drives memAddress = fetchAddress, memReadEnable = 1, memWriteEnable = 0.
- DATA drives memAddress = dataAddress, memDataIn = dataIn; load: memReadEnable = 1; store: memWriteEnable = dataAddress[10], memReadEnable = 0.
- Store with dataAddress[10] = 0: no memory write, dataValid and dataFault both pulse next cycle.
- IDLE: memory enables 0, memAddress/memDataIn 0.
- Response registers capture memDataOut at the edge ending the grant cycle into the granted port's data register; the other port's data register holds.

## Timing
- Reset (async assert, sync release): fetchValid, dataValid, dataFault 0; fetchData, dataOut 0; grantState IDLE; streakCount 0. Combinational outputs follow requests immediately after release.
- Latency: grant in cycle N, valid pulse for exactly cycle N+1; back-to-back grants give one valid per cycle.
- Ready is combinational on req; requester drops or changes req only after the cycle ready was seen high.
- Simultaneous requests: exactly one ready high; never both.
- Reset mid-transaction: in-flight response discarded; no valid after release for pre-reset grants.
- Store write takes effect at the edge ending cycle N; a load to same address in N+1 returns new data.

## Configuration
- MEMORY_ARBITER_STATS_EN defined: adds outputs fetchGrantCount, dataGrantCount, conflictCount (32 bits each, wrap at 2^32, reset to 0); conflictCount increments every cycle both requests are high.
- Undefined: ports and counters absent; arbitration behaviour identical.

## Test plan
- Fetch only, fetchAddress 0x00000010 → fetchReady same cycle, fetchValid next cycle with ROM word at 0x10, grantState 1.
- Store 0xDEADBEEF to 0x00000400, then load 0x00000400 → dataValid twice, dataOut 0xDEADBEEF on second pulse, dataFault 0.
- Store to 0x00000020 (ROM) → memWriteEnable stays 0, dataValid and dataFault pulse 1 cycle, ROM read of 0x20 unchanged.
- Both requests held continuously, MAX_DATA_STREAK 4 → grant sequence D,D,D,D,F,D,D,D,D,F…
- Assert resetN low one cycle after a load grant → no dataValid after release, all registered outputs 0.
- With MEMORY_ARBITER_STATS_EN, 10 contended cycles from reset → conflictCount 10, dataGrantCount 8, fetchGrantCount 2.
